memorybank_node_table: RTL

Parametrised successor to the single-port node memory bank. Stores per-neighbour node records (node ID in the low bits, other fields above it) for the EER-RL routing core. Adds the following over the single-port bank:
- per-entry valid bits
- separate write, invalidate and registered read ports
- a live occupancy count
- a sequential key-search engine, so the routing FSM can look up a node ID without scanning the table itself.

---
 rtl/memorybank_node_table_pkg.sv | 14 +
 rtl/memorybank_node_table_if.sv | 44 ++++
 rtl/memorybank_node_table_search_fsm.sv | 85 ++++++++
 rtl/memorybank_node_table.sv | 114 +++++++++++
 4 files changed

// File: rtl/memorybank_node_table_pkg.sv
// Shared defaults and search-state encoding for the node-table memory bank.
package memorybank_pkg;

  localparam int DEF_WORD_WIDTH = 16;
  localparam int DEF_DEPTH      = 64;
  localparam int DEF_KEY_WIDTH  = 8;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SEARCH = 2'd1,
    S_DONE   = 2'd2
  } srch_state_e;

endpackage

// File: rtl/memorybank_node_table_if.sv
// Bus bundle of the node table: write, invalidate, read, search and occupancy signals.
interface memorybank_node_table_if
  import memorybank_pkg::*;
#(
  parameter int WORD_WIDTH = DEF_WORD_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int KEY_WIDTH  = DEF_KEY_WIDTH
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int OCC_W = IDX_W + 1;

  logic                  wr_en;
  logic [IDX_W-1:0]      wr_index;
  logic [WORD_WIDTH-1:0] wr_data;
  logic                  inv_en;
  logic [IDX_W-1:0]      inv_index;
  logic                  rd_en;
  logic [IDX_W-1:0]      rd_index;
  logic [WORD_WIDTH-1:0] rd_data;
  logic                  rd_vld;
  logic                  rd_hit;
  logic                  srch_start;
  logic [KEY_WIDTH-1:0]  srch_key;
  logic                  srch_busy;
  logic                  srch_done;
  logic                  srch_hit;
  logic [IDX_W-1:0]      srch_index;
  logic [OCC_W-1:0]      occupancy;

  modport master (
    output wr_en, wr_index, wr_data, inv_en, inv_index, rd_en, rd_index,
           srch_start, srch_key,
    input  rd_data, rd_vld, rd_hit, srch_busy, srch_done, srch_hit, srch_index,
           occupancy
  );

  modport slave (
    input  wr_en, wr_index, wr_data, inv_en, inv_index, rd_en, rd_index,
           srch_start, srch_key,
    output rd_data, rd_vld, rd_hit, srch_busy, srch_done, srch_hit, srch_index,
           occupancy
  );

endinterface

// File: rtl/memorybank_node_table_search_fsm.sv
// Sequential key-search engine: walks the table one entry per cycle from index 0
// and reports the lowest valid entry whose key field matches.
module memorybank_search_fsm
  import memorybank_pkg::*;
#(
  parameter int DEPTH     = DEF_DEPTH,
  parameter int KEY_WIDTH = DEF_KEY_WIDTH,
  localparam int IDX_W    = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_start,
  input  logic [KEY_WIDTH-1:0] i_key,
  input  logic [KEY_WIDTH-1:0] i_cmp_key,
  input  logic                 i_cmp_vld,
  output logic [IDX_W-1:0]     o_ptr,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_hit,
  output logic [IDX_W-1:0]     o_index
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  srch_state_e          r_state;
  srch_state_e          w_state_nxt;
  logic [IDX_W-1:0]     r_ptr;
  logic [KEY_WIDTH-1:0] r_key;
  logic                 r_hit;
  logic [IDX_W-1:0]     r_index;
  logic                 w_match;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_match     = i_cmp_vld && (i_cmp_key == r_key);
    case (r_state)
      S_IDLE:   if (i_start) w_state_nxt = S_SEARCH;
      S_SEARCH: if (w_match || (r_ptr == LAST_IDX)) w_state_nxt = S_DONE;
      S_DONE:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Pointer and result registers; results persist until the next accepted start
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr   <= '0;
      r_hit   <= 1'b0;
      r_index <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (i_start) begin
          r_ptr   <= '0;
          r_hit   <= 1'b0;
          r_index <= '0;
        end
        S_SEARCH: begin
          if (w_match) begin
            r_hit   <= 1'b1;
            r_index <= r_ptr;
          end else if (r_ptr != LAST_IDX) begin
            r_ptr <= r_ptr + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if ((r_state == S_IDLE) && i_start) r_key <= i_key;
  end

  assign o_ptr   = r_ptr;
  assign o_busy  = (r_state != S_IDLE);
  assign o_done  = (r_state == S_DONE);
  assign o_hit   = r_hit;
  assign o_index = r_index;

endmodule

// File: rtl/memorybank_node_table.sv
// Node-record table with valid bits, occupancy count, registered read and key search.
// Optional build macro MEMBANK_RD_FWD_EN forwards same-cycle write/invalidate to the read port.
module memorybank_node_table
  import memorybank_pkg::*;
#(
  parameter int WORD_WIDTH = DEF_WORD_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int KEY_WIDTH  = DEF_KEY_WIDTH
) (
  input logic                  clk,
  input logic                  rst,
  memorybank_node_table_if.slave bus
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int OCC_W = IDX_W + 1;

  logic [WORD_WIDTH-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]      r_valid;
  logic [OCC_W-1:0]      r_occ;
  logic                  w_inc;
  logic                  w_dec;

  logic [WORD_WIDTH-1:0] w_rd_word_p0;
  logic                  w_rd_valid_p0;
  logic [WORD_WIDTH-1:0] r_rd_data_p1;
  logic                  r_rd_hit_p1;
  logic                  r_rd_vld_p1;

  logic [IDX_W-1:0]      w_ptr;
  logic [KEY_WIDTH-1:0]  w_cmp_key;
  logic                  w_cmp_vld;

  always_ff @(posedge clk) begin
    if (bus.wr_en) r_mem[bus.wr_index] <= bus.wr_data;
  end

  // Invalidate first so a same-index write overrides it
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
    end else begin
      if (bus.inv_en) r_valid[bus.inv_index] <= 1'b0;
      if (bus.wr_en)  r_valid[bus.wr_index]  <= 1'b1;
    end
  end

  always_comb begin
    w_inc = bus.wr_en && !r_valid[bus.wr_index];
    w_dec = bus.inv_en && r_valid[bus.inv_index] &&
            !(bus.wr_en && (bus.wr_index == bus.inv_index));
  end

  always_ff @(posedge clk) begin
    if (rst)                 r_occ <= '0;
    else if (w_inc && !w_dec) r_occ <= r_occ + OCC_W'(1);
    else if (!w_inc && w_dec) r_occ <= r_occ - OCC_W'(1);
  end

  // Read stage p0: array lookup with optional same-cycle forwarding
  always_comb begin
    w_rd_word_p0  = r_mem[bus.rd_index];
    w_rd_valid_p0 = r_valid[bus.rd_index];
`ifdef MEMBANK_RD_FWD_EN
    if (bus.inv_en && (bus.inv_index == bus.rd_index)) w_rd_valid_p0 = 1'b0;
    if (bus.wr_en && (bus.wr_index == bus.rd_index)) begin
      w_rd_word_p0  = bus.wr_data;
      w_rd_valid_p0 = 1'b1;
    end
`else
`endif
  end

  // Read stage p1: registered result, held while no read is issued
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_vld_p1  <= 1'b0;
      r_rd_data_p1 <= '0;
      r_rd_hit_p1  <= 1'b0;
    end else begin
      r_rd_vld_p1 <= bus.rd_en;
      if (bus.rd_en) begin
        r_rd_data_p1 <= w_rd_word_p0;
        r_rd_hit_p1  <= w_rd_valid_p0;
      end
    end
  end

  assign w_cmp_key = r_mem[w_ptr][KEY_WIDTH-1:0];
  assign w_cmp_vld = r_valid[w_ptr];

  memorybank_search_fsm #(
    .DEPTH     (DEPTH),
    .KEY_WIDTH (KEY_WIDTH)
  ) u_search (
    .clk       (clk),
    .rst       (rst),
    .i_start   (bus.srch_start),
    .i_key     (bus.srch_key),
    .i_cmp_key (w_cmp_key),
    .i_cmp_vld (w_cmp_vld),
    .o_ptr     (w_ptr),
    .o_busy    (bus.srch_busy),
    .o_done    (bus.srch_done),
    .o_hit     (bus.srch_hit),
    .o_index   (bus.srch_index)
  );

  assign bus.rd_data   = r_rd_data_p1;
  assign bus.rd_vld    = r_rd_vld_p1;
  assign bus.rd_hit    = r_rd_hit_p1;
  assign bus.occupancy = r_occ;

endmodule
